uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit blocks.
//   state_e               - receiver FSM state encoding
//   CLK_PER_BIT_9600_12M  - clocks per bit for 9600 baud at 12 MHz
//   DATA_BITS             - data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } state_e;

  localparam int CLK_PER_BIT_9600_12M = 1250;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: flop-chain synchronizer for an asynchronous input; all stages
// reset to 1 so an idle-high line reads idle straight out of reset.
//   clk, rst_n : clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (STAGES cycles of latency)
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//   clk, rst_n   : clock, async active-low reset
//   rx           : serial input, idle high, asynchronous
//   rx_data      : last correctly framed byte, LSB received first
//   rx_valid     : one-cycle pulse, rx_data updated in the same cycle
//   frame_error  : one-cycle pulse, stop bit sampled low
//   rx_busy      : frame in progress
//   parity_error : (UART_RX_PARITY_EN only) one-cycle pulse alongside the
//                  stop decision when even parity does not hold
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_9600_12M,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       rx_busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   vld_q, vld_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // Mid-start-bit check filters short low glitches on an idle line.
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          idx_d       = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      // Decide at mid-stop-bit and drop to IDLE right away so a following
      // start bit with zero idle time is still caught.
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d = sh_q;
            vld_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_d = ^{sh_q, par_q};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = vld_q;
  assign frame_error = ferr_q;
  assign rx_busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLK_PER_BIT=16, SYNC_STAGES=2.
// A negedge monitor logs every rx_valid byte and error pulse; each test task
// drives frames and compares the log against hand-computed values.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  uart_rx #(.CLK_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] vq[$];
  int fcnt = 0, pcnt = 0, both = 0, last_vld_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        vq.push_back(rx_data);
        last_vld_cyc = cyc;
      end
      if (frame_error) fcnt++;
      if (rx_valid && frame_error) both++;
`ifdef UART_RX_PARITY_EN
      if (parity_error && rx_valid) pcnt++;
`endif
    end
  end

  task automatic clear_log();
    vq.delete();
    fcnt = 0;
    pcnt = 0;
    both = 0;
  endtask

  // Called at a negedge; leaves rx idle high at a negedge.
  task automatic send_frame(input logic [7:0] b, input int per,
                            input logic stop_v, input logic par_flip);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (per) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_v;
    repeat (per) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    clear_log();
    t0 = cyc;
    send_frame(8'hA5, CPB, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (vq.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", vq.size()); end
    else begin
      checks++; if (vq[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", vq[0]); end
      checks++;
      if (last_vld_cyc - t0 < LAT || last_vld_cyc - t0 > LAT + 1) begin
        failures++; $display("FAIL single_latency got=%0d exp=%0d..%0d", last_vld_cyc - t0, LAT, LAT + 1);
      end
    end
    checks++; if (fcnt != 0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", fcnt); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
    clear_log();
    for (int i = 0; i < 3; i++) send_frame(exp[i], CPB, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (vq.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", vq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (vq[i] !== exp[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, vq[i], exp[i]); end
      end
    end
    checks++; if (both != 0 || fcnt != 0) begin failures++; $display("FAIL b2b_errors got=%0d exp=0", fcnt + both); end
  endtask

  task automatic test_glitch();
    clear_log();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checks++; if (vq.size() != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vq.size()); end
    checks++; if (fcnt != 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", fcnt); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_frame_error();
    clear_log();
    send_frame(8'h3C, CPB, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    checks++; if (fcnt != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fcnt); end
    checks++; if (vq.size() != 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", vq.size()); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL ferr_data_kept got=%h exp=55", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h81;
    clear_log();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (3) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", rx_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_valid !== 1'b0 || frame_error !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%b%b exp=00", rx_valid, frame_error); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h7E, CPB, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checks++; if (vq.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", vq.size()); end
    else begin
      checks++; if (vq[0] !== 8'h7E) begin failures++; $display("FAIL midrst_rx got=%h exp=7e", vq[0]); end
    end
    checks++; if (fcnt != 0) begin failures++; $display("FAIL midrst_ferr got=%0d exp=0", fcnt); end
  endtask

  task automatic test_baud_skew();
    int per [2];
    per[0] = CPB - 1; per[1] = CPB + 1;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      send_frame(8'hC3, per[k], 1'b1, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      checks++; if (vq.size() != 1) begin failures++; $display("FAIL skew%0d_count got=%0d exp=1", per[k], vq.size()); end
      else begin
        checks++; if (vq[0] !== 8'hC3) begin failures++; $display("FAIL skew%0d_data got=%h exp=c3", per[k], vq[0]); end
      end
      checks++; if (fcnt != 0) begin failures++; $display("FAIL skew%0d_ferr got=%0d exp=0", per[k], fcnt); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_log();
    send_frame(8'hC3, CPB, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    checks++; if (pcnt != 1) begin failures++; $display("FAIL parity_err_with_valid got=%0d exp=1", pcnt); end
    checks++; if (vq.size() != 1 || vq[0] !== 8'hC3) begin failures++; $display("FAIL parity_data got=%0d entries exp=1 c3", vq.size()); end
    clear_log();
    send_frame(8'hC3, CPB, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checks++; if (pcnt != 0) begin failures++; $display("FAIL parity_good got=%0d exp=0", pcnt); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_baud_skew();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
